// File: rtl/uart_autobaud_pkg.sv
// Shared constants for the UART auto-baud detector: FSM encoding and 0x55 frame geometry.
package uart_autobaud_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_ARM        = 3'd1;
    localparam logic [2:0] ST_WAIT_START = 3'd2;
    localparam logic [2:0] ST_MEASURE    = 3'd3;
    localparam logic [2:0] ST_WAIT_STOP  = 3'd4;
    localparam logic [2:0] ST_DONE       = 3'd5;
    localparam logic [2:0] ST_ERR        = 3'd6;

    // 0x55 has five falling edges; first to fifth spans 2^AB_SHIFT bit times.
    localparam int AB_EDGES = 5;
    localparam int AB_SHIFT = 3;

endpackage

// File: rtl/uart_autobaud_sync.sv
// Two-flop synchronizer for the serial line plus rise/fall detection; all flops reset to idle-high.
module uart_autobaud_sync (
    input  logic clk_i,
    input  logic rst_int,
    input  logic rxd_i,
    output logic line_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk_i or posedge rst_int) begin
        if (rst_int) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rxd_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign line_o = sync2_q;
    assign rise_o = sync2_q & ~prev_q;
    assign fall_o = ~sync2_q & prev_q;

endmodule

// File: rtl/uart_autobaud.sv
// Auto-baud detector: times a 0x55 calibration frame and publishes clocks-per-bit.
// Optional per-period consistency check is built when UART_AUTOBAUD_CHECK_EN is defined.
// valid_o is a one-cycle strobe with no back-pressure; bit_duration_o holds until the next success.
module uart_autobaud
    import uart_autobaud_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 868
) (
    input  logic             clk_i,
    input  logic             rst_int,
    input  logic             start_i,
    input  logic             rxd_i,
    output logic [DIV_W-1:0] bit_duration_o,
    output logic             valid_o,
    output logic             locked_o,
    output logic             error_o,
    output logic             busy_o,
    output logic [2:0]       state_o
);

    localparam int TOT_W = DIV_W + 3;
    localparam int PER_W = DIV_W + 1;

    logic             line_s;
    logic             rise_s;
    logic             fall_s;

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [TOT_W-1:0] tot_q;
    logic [PER_W-1:0] per_q;
    logic [2:0]       fall_cnt_q;
    logic [DIV_W-1:0] res_q;

    logic [TOT_W:0]   tot_rnd;
    logic [PER_W-1:0] res_full;
    logic             res_bad;
    logic             tot_sat;
    logic             per_sat;
    logic             last_fall;
    logic             stop_late;
    logic             period_bad;

    uart_autobaud_sync u_sync (
        .clk_i  (clk_i),
        .rst_int(rst_int),
        .rxd_i  (rxd_i),
        .line_o (line_s),
        .rise_o (rise_s),
        .fall_o (fall_s)
    );

    // Round to nearest: (tot + 4) >> 3; an extra top bit flags overflow of DIV_W.
    assign tot_rnd   = {1'b0, tot_q} + (TOT_W+1)'(4);
    assign res_full  = PER_W'(tot_rnd >> AB_SHIFT);
    assign res_bad   = (res_full < PER_W'(2)) || res_full[DIV_W];
    assign tot_sat   = &tot_q;
    assign per_sat   = &per_q;
    assign last_fall = fall_s && (fall_cnt_q == 3'(AB_EDGES - 1));
    assign stop_late = per_q >= {res_q, 1'b0};

`ifdef UART_AUTOBAUD_CHECK_EN
    logic [PER_W-1:0] p0_q;
    logic [PER_W-1:0] per_diff;

    assign per_diff   = (per_q > p0_q) ? (per_q - p0_q) : (p0_q - per_q);
    assign period_bad = fall_s && (fall_cnt_q >= 3'd2) && (per_diff > (p0_q >> 2));

    always_ff @(posedge clk_i or posedge rst_int) begin
        if (rst_int) begin
            p0_q <= '0;
        end else if (state_q == ST_MEASURE && fall_s && fall_cnt_q == 3'd1) begin
            p0_q <= per_q;
        end
    end
`else
    assign period_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       state_d = ST_IDLE;
            ST_ARM:        if (line_s) state_d = ST_WAIT_START;
            ST_WAIT_START: if (fall_s) state_d = ST_MEASURE;
            ST_MEASURE: begin
                if (tot_sat) begin
                    state_d = ST_ERR;
                end else if (period_bad) begin
                    state_d = ST_ERR;
                end else if (last_fall) begin
                    state_d = res_bad ? ST_ERR : ST_WAIT_STOP;
                end
            end
            ST_WAIT_STOP: begin
                if (rise_s) begin
                    state_d = ST_DONE;
                end else if (stop_late) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE:       state_d = ST_IDLE;
            ST_ERR:        state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
        // A re-arm request overrides whatever the FSM was doing, including DONE.
        if (start_i) begin
            state_d = ST_ARM;
        end
    end

    always_ff @(posedge clk_i or posedge rst_int) begin
        if (rst_int) begin
            state_q    <= ST_IDLE;
            tot_q      <= '0;
            per_q      <= '0;
            fall_cnt_q <= '0;
            res_q      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_WAIT_START: begin
                    if (fall_s) begin
                        tot_q      <= TOT_W'(1);
                        per_q      <= PER_W'(1);
                        fall_cnt_q <= 3'd1;
                    end
                end
                ST_MEASURE: begin
                    if (!tot_sat) tot_q <= tot_q + TOT_W'(1);
                    if (last_fall) begin
                        per_q <= '0;
                        res_q <= res_full[DIV_W-1:0];
                    end else if (fall_s) begin
                        per_q <= PER_W'(1);
                    end else if (!per_sat) begin
                        per_q <= per_q + PER_W'(1);
                    end
                    if (fall_s) fall_cnt_q <= fall_cnt_q + 3'd1;
                end
                ST_WAIT_STOP: begin
                    if (!per_sat) per_q <= per_q + PER_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_int) begin
        if (rst_int) begin
            bit_duration_o <= DIV_W'(DEFAULT_DIV);
            valid_o        <= 1'b0;
            locked_o       <= 1'b0;
            error_o        <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (start_i) begin
                locked_o <= 1'b0;
                error_o  <= 1'b0;
            end else if (state_q == ST_DONE) begin
                bit_duration_o <= res_q;
                valid_o        <= 1'b1;
                locked_o       <= 1'b1;
            end else if (state_q == ST_ERR) begin
                error_o <= 1'b1;
            end
        end
    end

    assign busy_o  = (state_q != ST_IDLE);
    assign state_o = state_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud: a 16-bit instance for lock/relock/abort/reset cases
// and an 8-bit instance for the total-count saturation case.
module tb_uart_autobaud;

    logic        clk_i = 1'b0;
    logic        rst_int;
    logic        start_i;
    logic        rxd_i;
    logic [15:0] bd;
    logic        valid;
    logic        locked;
    logic        error;
    logic        busy;
    logic [2:0]  st;

    logic        start8;
    logic        rxd8;
    logic [7:0]  bd8;
    logic        valid8;
    logic        locked8;
    logic        error8;
    logic        busy8;
    logic [2:0]  st8;

    int checks = 0;
    int errors = 0;
    int vcnt   = 0;
    int vcnt8  = 0;

    always #5 clk_i = ~clk_i;

    uart_autobaud #(.DIV_W(16), .DEFAULT_DIV(868)) u_dut (
        .clk_i         (clk_i),
        .rst_int       (rst_int),
        .start_i       (start_i),
        .rxd_i         (rxd_i),
        .bit_duration_o(bd),
        .valid_o       (valid),
        .locked_o      (locked),
        .error_o       (error),
        .busy_o        (busy),
        .state_o       (st)
    );

    uart_autobaud #(.DIV_W(8), .DEFAULT_DIV(200)) u_dut8 (
        .clk_i         (clk_i),
        .rst_int       (rst_int),
        .start_i       (start8),
        .rxd_i         (rxd8),
        .bit_duration_o(bd8),
        .valid_o       (valid8),
        .locked_o      (locked8),
        .error_o       (error8),
        .busy_o        (busy8),
        .state_o       (st8)
    );

    always @(posedge clk_i) begin
        if (valid === 1'b1) vcnt <= vcnt + 1;
        if (valid8 === 1'b1) vcnt8 <= vcnt8 + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input bit sel8, input logic v, input int n);
        if (sel8) rxd8 = v;
        else rxd_i = v;
        tick(n);
    endtask

    task automatic send_byte(input bit sel8, input logic [7:0] b, input int t);
        drive(sel8, 1'b0, t);
        for (int i = 0; i < 8; i++) drive(sel8, b[i], t);
        drive(sel8, 1'b1, t);
    endtask

    task automatic pulse_start(input bit sel8);
        if (sel8) start8 = 1'b1;
        else start_i = 1'b1;
        tick(1);
        start8  = 1'b0;
        start_i = 1'b0;
        tick(6);
    endtask

    task automatic test_reset;
        checks++; if (bd !== 16'd868) begin errors++; $display("FAIL reset_bd actual=%0d required=868", bd); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid actual=%b required=0", valid); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked actual=%b required=0", locked); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error actual=%b required=0", error); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy actual=%b required=0", busy); end
        checks++; if (st !== 3'd0) begin errors++; $display("FAIL reset_state actual=%0d required=0", st); end
        checks++; if (bd8 !== 8'd200) begin errors++; $display("FAIL reset_bd8 actual=%0d required=200", bd8); end
    endtask

    task automatic test_lock16;
        int v0;
        v0 = vcnt;
        pulse_start(1'b0);
        send_byte(1'b0, 8'h55, 16);
        tick(4);
        checks++; if (vcnt - v0 !== 1) begin errors++; $display("FAIL lock16_valid_count actual=%0d required=1", vcnt - v0); end
        checks++; if (bd !== 16'd16) begin errors++; $display("FAIL lock16_bd actual=%0d required=16", bd); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock16_locked actual=%b required=1", locked); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL lock16_error actual=%b required=0", error); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lock16_busy actual=%b required=0", busy); end
    endtask

    task automatic test_relock;
        int v0;
        v0 = vcnt;
        pulse_start(1'b0);
        send_byte(1'b0, 8'h55, 868);
        tick(4);
        checks++; if (bd !== 16'd868) begin errors++; $display("FAIL relock_bd868 actual=%0d required=868", bd); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock_locked1 actual=%b required=1", locked); end
        pulse_start(1'b0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL relock_locked_drop actual=%b required=0", locked); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL relock_busy actual=%b required=1", busy); end
        send_byte(1'b0, 8'h55, 100);
        tick(4);
        checks++; if (bd !== 16'd100) begin errors++; $display("FAIL relock_bd100 actual=%0d required=100", bd); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock_locked2 actual=%b required=1", locked); end
        checks++; if (vcnt - v0 !== 2) begin errors++; $display("FAIL relock_valid_count actual=%0d required=2", vcnt - v0); end
    endtask

    task automatic test_timeout8;
        int v0;
        pulse_start(1'b1);
        send_byte(1'b1, 8'h55, 16);
        tick(4);
        checks++; if (bd8 !== 8'd16) begin errors++; $display("FAIL tmo8_prelock_bd actual=%0d required=16", bd8); end
        v0 = vcnt8;
        pulse_start(1'b1);
        send_byte(1'b1, 8'h00, 16);
        for (int i = 0; i < 3000 && error8 !== 1'b1; i++) tick(1);
        checks++; if (error8 !== 1'b1) begin errors++; $display("FAIL tmo8_error actual=%b required=1", error8); end
        checks++; if (bd8 !== 8'd16) begin errors++; $display("FAIL tmo8_bd_kept actual=%0d required=16", bd8); end
        checks++; if (locked8 !== 1'b0) begin errors++; $display("FAIL tmo8_locked actual=%b required=0", locked8); end
        checks++; if (vcnt8 - v0 !== 0) begin errors++; $display("FAIL tmo8_valid_count actual=%0d required=0", vcnt8 - v0); end
    endtask

    task automatic test_period;
        int v0;
        v0 = vcnt;
        pulse_start(1'b0);
        drive(1'b0, 1'b0, 16);
        drive(1'b0, 1'b1, 16);
        drive(1'b0, 1'b0, 16);
        drive(1'b0, 1'b1, 16);
`ifdef UART_AUTOBAUD_CHECK_EN
        drive(1'b0, 1'b0, 8);
        drive(1'b0, 1'b1, 8);
`else
        drive(1'b0, 1'b0, 16);
        drive(1'b0, 1'b1, 8);
`endif
        drive(1'b0, 1'b0, 16);
        drive(1'b0, 1'b1, 16);
        drive(1'b0, 1'b0, 16);
        drive(1'b0, 1'b1, 16);
        tick(4);
`ifdef UART_AUTOBAUD_CHECK_EN
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL period_error actual=%b required=1", error); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL period_locked actual=%b required=0", locked); end
        checks++; if (bd !== 16'd100) begin errors++; $display("FAIL period_bd_kept actual=%0d required=100", bd); end
        checks++; if (vcnt - v0 !== 0) begin errors++; $display("FAIL period_valid_count actual=%0d required=0", vcnt - v0); end
`else
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL period_error actual=%b required=0", error); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL period_locked actual=%b required=1", locked); end
        checks++; if (bd !== 16'd15) begin errors++; $display("FAIL period_bd actual=%0d required=15", bd); end
        checks++; if (vcnt - v0 !== 1) begin errors++; $display("FAIL period_valid_count actual=%0d required=1", vcnt - v0); end
`endif
    endtask

    task automatic test_rst_mid;
        pulse_start(1'b0);
        drive(1'b0, 1'b0, 16);
        drive(1'b0, 1'b1, 16);
        drive(1'b0, 1'b0, 8);
        checks++; if (st !== 3'd3) begin errors++; $display("FAIL rstmid_in_measure actual=%0d required=3", st); end
        rst_int = 1'b1;
        tick(2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy actual=%b required=0", busy); end
        checks++; if (bd !== 16'd868) begin errors++; $display("FAIL rstmid_bd actual=%0d required=868", bd); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid actual=%b required=0", valid); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rstmid_locked actual=%b required=0", locked); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL rstmid_error actual=%b required=0", error); end
        rxd_i   = 1'b1;
        rst_int = 1'b0;
        tick(4);
        pulse_start(1'b0);
        send_byte(1'b0, 8'h55, 16);
        tick(4);
        checks++; if (bd !== 16'd16) begin errors++; $display("FAIL rstmid_relock_bd actual=%0d required=16", bd); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rstmid_relock_locked actual=%b required=1", locked); end
    endtask

    task automatic test_abort;
        int v0;
        v0 = vcnt;
        pulse_start(1'b0);
        drive(1'b0, 1'b0, 20);
        drive(1'b0, 1'b1, 20);
        drive(1'b0, 1'b0, 20);
        drive(1'b0, 1'b1, 20);
        pulse_start(1'b0);
        tick(20);
        send_byte(1'b0, 8'h55, 20);
        tick(4);
        checks++; if (vcnt - v0 !== 1) begin errors++; $display("FAIL abort_valid_count actual=%0d required=1", vcnt - v0); end
        checks++; if (bd !== 16'd20) begin errors++; $display("FAIL abort_bd actual=%0d required=20", bd); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL abort_locked actual=%b required=1", locked); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL abort_error actual=%b required=0", error); end
    endtask

    initial begin
        rst_int = 1'b1;
        start_i = 1'b0;
        rxd_i   = 1'b1;
        start8  = 1'b0;
        rxd8    = 1'b1;
        tick(3);
        rst_int = 1'b0;
        tick(2);
        test_reset();
        test_lock16();
        test_relock();
        test_timeout8();
        test_period();
        test_rst_mid();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
